lsf_peak_collector: RTL and testbench
=====================================

# lsf_peak_collector

Window sequencer and peak reporter directly downstream of the LSF histogram stage. It opens and closes segment windows, drives the histogram's enable and bin-clear controls, and tracks the running local maximum the histogram emits. At window close it reports the winning r-bin and count if the count meets a hit threshold, then clears the histogram for the next window.

## Interface
Parameters:
- RBINS, 128, histogram bins; r-bin width is $clog2(RBINS)
- CNT_W, 4, bin count width
- MIN_HITS, 3, minimum count for a reported peak
- DRAIN_CYC, 4, cycles waited after window end for the histogram pipeline to flush
- TIMEOUT, 64, maximum ACCUM cycles (only with LSF_PEAK_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- win_start  in  1  pulse: open a segment window
- win_end  in  1  pulse: last hit of the window has been sent to the histogram
- local_max_rbin  in  $clog2(RBINS)  histogram local-max bin
- local_max_count  in  CNT_W  histogram local-max count
- local_max_vld  in  1  histogram local-max update strobe
- hist_enable  out  1  histogram enable
- hist_reset  out  1  histogram bin clear, one-cycle pulse
- peak_rbin  out  $clog2(RBINS)  reported bin
- peak_count  out  CNT_W  reported count
- peak_vld  out  1  peak valid
- peak_ready  in  1  consumer ready
- busy  out  1  state is not IDLE
- win_drop  out  1  one-cycle pulse: win_start ignored
- n_reject  out  8  saturating count of windows below MIN_HITS
- timeout_err  out  1  sticky: a window was closed by timeout

## Operation
- States: IDLE, ACCUM, DRAIN, OUTPUT, CLEAR.
- IDLE:
  - win_start goes to ACCUM and clears best_rbin and best_count to 0.
  - win_start and win_end in the same cycle go straight to DRAIN, with best_rbin and best_count cleared.
- ACCUM:
  - hist_enable=1.
  - win_end goes to DRAIN.
- DRAIN:
  - hist_enable=1.
  - Lasts exactly DRAIN_CYC cycles (down-counter), then evaluates.
- Best tracking, in ACCUM and DRAIN only:
  - On local_max_vld with local_max_count > best_count, capture both local_max_count and local_max_rbin.
  - An equal count does not replace the stored bin.
  - local_max_vld is ignored in every other state.
- Evaluation at the end of DRAIN:
  - best_count >= MIN_HITS goes to OUTPUT.
  - Otherwise go to CLEAR and increment n_reject, saturating at 255.
- OUTPUT:
  - peak_vld=1; peak_rbin and peak_count are held stable until the cycle in which peak_vld & peak_ready.
  - That handshake goes to CLEAR.
- CLEAR:
  - hist_reset=1 and hist_enable=0 for exactly one cycle, then IDLE.
- win_start outside IDLE is ignored and pulses win_drop.
- win_end outside ACCUM (and outside the IDLE simultaneous case) is ignored silently.
- All outputs are registered.
- Reset values: state=IDLE; hist_enable, hist_reset, peak_vld, busy, win_drop, timeout_err are 0; peak_rbin, peak_count, n_reject and internal counters are 0.
- Reset asserted mid-window aborts the window immediately. No hist_reset pulse is generated; the histogram's own reset clears it.

## Timing
- win_start sampled at edge k: ACCUM and hist_enable=1 from cycle k+1.
- win_end sampled at edge e: DRAIN for cycles e+1 through e+DRAIN_CYC; OUTPUT (peak_vld=1) or CLEAR from cycle e+1+DRAIN_CYC.
- With peak_ready held high, handshake completes at e+1+DRAIN_CYC; hist_reset is high at e+2+DRAIN_CYC; IDLE at e+3+DRAIN_CYC.
- A win_start at e+3+DRAIN_CYC is accepted; an earlier win_start is dropped.
- DRAIN_CYC must be at least the histogram's input-to-local_max_vld latency (3).

## Configuration
- LSF_PEAK_TIMEOUT_EN defined:
  - A cycle counter runs in ACCUM.
  - After TIMEOUT cycles in ACCUM without win_end, the block goes to DRAIN as if win_end had arrived, and sets timeout_err.
  - timeout_err is cleared only by rst.
- Not defined:
  - ACCUM waits indefinitely for win_end.
  - timeout_err is tied to 0.
  - No timeout counter is instantiated.

## Test plan
- Basic peak: win_start, local_max_vld updates (rbin 10,cnt 1), (rbin 10,cnt 2), (rbin 42,cnt 5), win_end -> peak_vld at e+5 with peak_rbin=42, peak_count=5; one hist_reset pulse after the handshake.
- Tie: updates (rbin 7,cnt 4) then (rbin 9,cnt 4) -> peak_rbin=7, peak_count=4.
- Below threshold: best count 2 with MIN_HITS=3 -> no peak_vld; n_reject increments 0->1; hist_reset pulses at e+5.
- Backpressure: hold peak_ready=0 for 10 cycles -> peak_vld and data stable for all 10 cycles; extra local_max_vld pulses and win_start are ignored, and each win_start pulses win_drop.
- Late update in drain: local_max_vld (rbin 3,cnt 6) at e+3 -> captured and reported as rbin 3, cnt 6.
- Timeout (macro on, TIMEOUT=64): win_start with no win_end -> DRAIN after 64 ACCUM cycles and timeout_err=1. Assert rst mid-ACCUM -> all outputs return to 0 and state returns to IDLE immediately.

Source files
------------

// File: rtl/lsf_peak_collector.sv
// lsf_peak_collector: segment window sequencer and peak reporter behind the LSF histogram.
// Optional ACCUM watchdog is enabled by defining LSF_PEAK_TIMEOUT_EN.
module lsf_peak_collector #(
    parameter int RBINS     = 128,
    parameter int CNT_W     = 4,
    parameter int MIN_HITS  = 3,
    parameter int DRAIN_CYC = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     win_start,
    input  logic                     win_end,
    input  logic [$clog2(RBINS)-1:0] local_max_rbin,
    input  logic [CNT_W-1:0]         local_max_count,
    input  logic                     local_max_vld,
    output logic                     hist_enable,
    output logic                     hist_reset,
    output logic [$clog2(RBINS)-1:0] peak_rbin,
    output logic [CNT_W-1:0]         peak_count,
    output logic                     peak_vld,
    input  logic                     peak_ready,
    output logic                     busy,
    output logic                     win_drop,
    output logic [7:0]               n_reject,
    output logic                     timeout_err
);

    localparam int RW = $clog2(RBINS);
    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        DRAIN,
        OUTPUT,
        CLEAR
    } state_t;

    state_t          state;
    logic [DW-1:0]   drain_cnt;
    logic [RW-1:0]   best_rbin;
    logic [CNT_W-1:0] best_count;

    logic            take;
    logic [RW-1:0]   cand_rbin;
    logic [CNT_W-1:0] cand_count;
    logic            hit;
    logic            to_hit;

    // Candidate best including an update arriving in the evaluation cycle
    always_comb begin
        take       = 1'b0;
        cand_rbin  = best_rbin;
        cand_count = best_count;
        if ((state == ACCUM || state == DRAIN) && local_max_vld &&
            (local_max_count > best_count)) begin
            take       = 1'b1;
            cand_rbin  = local_max_rbin;
            cand_count = local_max_count;
        end
        hit = (cand_count >= CNT_W'(MIN_HITS));
    end

`ifdef LSF_PEAK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] to_cnt;

    assign to_hit = (state == ACCUM) && !win_end &&
                    (to_cnt == TW'(TIMEOUT - 1));

    // Count ACCUM cycles; a window that never sees win_end is forced closed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state != ACCUM)
                to_cnt <= '0;
            else if (!win_end)
                to_cnt <= to_cnt + TW'(1);
            if (to_hit)
                timeout_err <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT == 0);
    assign to_hit         = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    // Window FSM with registered histogram controls and peak report
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            drain_cnt   <= '0;
            best_rbin   <= '0;
            best_count  <= '0;
            hist_enable <= 1'b0;
            hist_reset  <= 1'b0;
            peak_rbin   <= '0;
            peak_count  <= '0;
            peak_vld    <= 1'b0;
            busy        <= 1'b0;
            win_drop    <= 1'b0;
            n_reject    <= '0;
        end else begin
            hist_reset <= 1'b0;
            win_drop   <= win_start && (state != IDLE);
            if (take) begin
                best_rbin  <= local_max_rbin;
                best_count <= local_max_count;
            end
            unique case (state)
                IDLE: begin
                    if (win_start) begin
                        best_rbin   <= '0;
                        best_count  <= '0;
                        hist_enable <= 1'b1;
                        busy        <= 1'b1;
                        if (win_end) begin
                            state     <= DRAIN;
                            drain_cnt <= DW'(DRAIN_CYC - 1);
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (win_end || to_hit) begin
                        state     <= DRAIN;
                        drain_cnt <= DW'(DRAIN_CYC - 1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        hist_enable <= 1'b0;
                        if (hit) begin
                            state      <= OUTPUT;
                            peak_vld   <= 1'b1;
                            peak_rbin  <= cand_rbin;
                            peak_count <= cand_count;
                        end else begin
                            state      <= CLEAR;
                            hist_reset <= 1'b1;
                            if (n_reject != 8'hFF)
                                n_reject <= n_reject + 8'd1;
                        end
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                OUTPUT: begin
                    if (peak_ready) begin
                        state      <= CLEAR;
                        peak_vld   <= 1'b0;
                        hist_reset <= 1'b1;
                    end
                end
                CLEAR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    hist_enable <= 1'b0;
                    peak_vld    <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsf_peak_collector.sv
// tb_lsf_peak_collector: randomized window traffic checked against a
// per-window reference of the best-bin rule and reject counter.
module tb_lsf_peak_collector;

    localparam int RBINS     = 128;
    localparam int CNT_W     = 4;
    localparam int MIN_HITS  = 3;
    localparam int DRAIN_CYC = 4;
    localparam int TIMEOUT   = 64;
    localparam int RW        = $clog2(RBINS);

    logic             clk = 1'b0;
    logic             rst;
    logic             win_start;
    logic             win_end;
    logic [RW-1:0]    local_max_rbin;
    logic [CNT_W-1:0] local_max_count;
    logic             local_max_vld;
    logic             hist_enable;
    logic             hist_reset;
    logic [RW-1:0]    peak_rbin;
    logic [CNT_W-1:0] peak_count;
    logic             peak_vld;
    logic             peak_ready;
    logic             busy;
    logic             win_drop;
    logic [7:0]       n_reject;
    logic             timeout_err;

    int checks   = 0;
    int failures = 0;
    int m_rej    = 0;
    int m_best_c;
    int m_best_r;

    int q_r[$];
    int q_c[$];
    bit d_v[DRAIN_CYC];
    int d_r[DRAIN_CYC];
    int d_c[DRAIN_CYC];

    lsf_peak_collector #(
        .RBINS(RBINS), .CNT_W(CNT_W), .MIN_HITS(MIN_HITS),
        .DRAIN_CYC(DRAIN_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .win_start(win_start), .win_end(win_end),
        .local_max_rbin(local_max_rbin),
        .local_max_count(local_max_count),
        .local_max_vld(local_max_vld),
        .hist_enable(hist_enable), .hist_reset(hist_reset),
        .peak_rbin(peak_rbin), .peak_count(peak_count),
        .peak_vld(peak_vld), .peak_ready(peak_ready),
        .busy(busy), .win_drop(win_drop),
        .n_reject(n_reject), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #10ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Present one local-max update; 'track' says the window would accept it
    task automatic upd(input bit v, input int r, input int c, input bit track);
        local_max_vld   = v;
        local_max_rbin  = r[RW-1:0];
        local_max_count = c[CNT_W-1:0];
        if (v && track && c > m_best_c) begin
            m_best_c = c;
            m_best_r = r;
        end
    endtask

    task automatic clear_plan;
        q_r.delete();
        q_c.delete();
        for (int i = 0; i < DRAIN_CYC; i++) begin
            d_v[i] = 1'b0;
            d_r[i] = 0;
            d_c[i] = 0;
        end
    endtask

    task automatic count_reject;
        if (m_rej < 255)
            m_rej++;
    endtask

    task automatic run_window(input bit simul, input int ready_wait,
                              input bit rnd);
        bit ws;
        m_best_c   = 0;
        m_best_r   = 0;
        peak_ready = (ready_wait == 0);
        win_start  = 1'b1;
        win_end    = simul;
        tick();
        win_start = 1'b0;
        win_end   = 1'b0;
        check("start_en", hist_enable, 1);
        check("start_busy", busy, 1);
        if (!simul) begin
            foreach (q_r[i]) begin
                upd(1'b1, q_r[i], q_c[i], 1'b1);
                ws = rnd && ($urandom_range(0, 5) == 0);
                win_start = ws;
                tick();
                win_start = 1'b0;
                upd(1'b0, 0, 0, 1'b0);
                check("accum_drop", win_drop, ws);
                if (rnd)
                    repeat ($urandom_range(0, 2)) tick();
            end
            win_end = 1'b1;
            tick();
            win_end = 1'b0;
        end
        for (int i = 0; i < DRAIN_CYC; i++) begin
            check("drain_en", hist_enable, 1);
            check("drain_vld", peak_vld, 0);
            check("drain_clr", hist_reset, 0);
            upd(d_v[i], d_r[i], d_c[i], 1'b1);
            win_end = rnd && ($urandom_range(0, 1) == 1);
            tick();
            upd(1'b0, 0, 0, 1'b0);
            win_end = 1'b0;
        end
        if (m_best_c >= MIN_HITS) begin
            check("out_vld", peak_vld, 1);
            check("out_rbin", peak_rbin, m_best_r);
            check("out_count", peak_count, m_best_c);
            check("out_clr", hist_reset, 0);
            for (int i = 0; i < ready_wait; i++) begin
                upd(1'b1, $urandom_range(0, RBINS - 1), 15, 1'b0);
                ws = ($urandom_range(0, 1) == 1);
                win_start = ws;
                win_end = ($urandom_range(0, 1) == 1);
                tick();
                upd(1'b0, 0, 0, 1'b0);
                win_start = 1'b0;
                win_end = 1'b0;
                check("bp_drop", win_drop, ws);
                check("bp_vld", peak_vld, 1);
                check("bp_rbin", peak_rbin, m_best_r);
                check("bp_count", peak_count, m_best_c);
                check("bp_clr", hist_reset, 0);
            end
            peak_ready = 1'b1;
            tick();
            check("hs_clr", hist_reset, 1);
            check("hs_vld", peak_vld, 0);
            check("hs_en", hist_enable, 0);
        end else begin
            count_reject();
            check("rej_vld", peak_vld, 0);
            check("rej_clr", hist_reset, 1);
            check("rej_en", hist_enable, 0);
            check("rej_cnt", n_reject, m_rej);
        end
        tick();
        check("idle_clr", hist_reset, 0);
        check("idle_busy", busy, 0);
        check("idle_vld", peak_vld, 0);
        clear_plan();
    endtask

    initial begin
        rst        = 1'b1;
        win_start  = 1'b0;
        win_end    = 1'b0;
        peak_ready = 1'b1;
        upd(1'b0, 0, 0, 1'b0);
        clear_plan();
        tick();
        tick();
        check("rst_en", hist_enable, 0);
        check("rst_clr", hist_reset, 0);
        check("rst_vld", peak_vld, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", win_drop, 0);
        check("rst_rej", n_reject, 0);
        check("rst_to", timeout_err, 0);
        check("rst_rbin", peak_rbin, 0);
        check("rst_count", peak_count, 0);
        rst = 1'b0;
        tick();

        // Basic peak
        q_r = '{10, 10, 42};
        q_c = '{1, 2, 5};
        run_window(1'b0, 0, 1'b0);

        // Tie keeps first bin
        q_r = '{7, 9};
        q_c = '{4, 4};
        run_window(1'b0, 0, 1'b0);

        // Below threshold
        q_r = '{5};
        q_c = '{2};
        run_window(1'b0, 0, 1'b0);

        // Backpressure
        q_r = '{20, 21};
        q_c = '{9, 3};
        run_window(1'b0, 10, 1'b0);

        // Late update in drain, cycle e+3
        q_r = '{1};
        q_c = '{2};
        d_v[2] = 1'b1;
        d_r[2] = 3;
        d_c[2] = 6;
        run_window(1'b0, 0, 1'b0);

        // Update in the final drain cycle still counts
        d_v[DRAIN_CYC-1] = 1'b1;
        d_r[DRAIN_CYC-1] = 99;
        d_c[DRAIN_CYC-1] = 3;
        run_window(1'b1, 1, 1'b0);

        // Randomized windows
        for (int w = 0; w < 40; w++) begin
            int n;
            n = $urandom_range(0, 6);
            for (int i = 0; i < n; i++) begin
                q_r.push_back($urandom_range(0, RBINS - 1));
                q_c.push_back($urandom_range(0, 15));
            end
            for (int i = 0; i < DRAIN_CYC; i++) begin
                d_v[i] = ($urandom_range(0, 3) == 0);
                d_r[i] = $urandom_range(0, RBINS - 1);
                d_c[i] = $urandom_range(0, 15);
            end
            run_window($urandom_range(0, 7) == 0, $urandom_range(0, 3), 1'b1);
        end

        // Timeout behaviour
        win_start = 1'b1;
        tick();
        win_start = 1'b0;
`ifdef LSF_PEAK_TIMEOUT_EN
        repeat (TIMEOUT - 1) tick();
        check("to_pre_err", timeout_err, 0);
        check("to_pre_en", hist_enable, 1);
        tick();
        check("to_err", timeout_err, 1);
        repeat (DRAIN_CYC - 1) tick();
        check("to_drain_clr", hist_reset, 0);
        tick();
        count_reject();
        check("to_rej_clr", hist_reset, 1);
        check("to_rej_cnt", n_reject, m_rej);
        tick();
        check("to_idle_busy", busy, 0);
        check("to_sticky", timeout_err, 1);
`else
        repeat (TIMEOUT + 20) tick();
        check("nto_en", hist_enable, 1);
        check("nto_busy", busy, 1);
        check("nto_err", timeout_err, 0);
        win_end = 1'b1;
        tick();
        win_end = 1'b0;
        repeat (DRAIN_CYC) tick();
        count_reject();
        check("nto_rej_clr", hist_reset, 1);
        check("nto_rej_cnt", n_reject, m_rej);
        tick();
        check("nto_idle", busy, 0);
`endif

        // Reset asserted mid-ACCUM
        q_r = '{30};
        q_c = '{8};
        win_start = 1'b1;
        tick();
        win_start = 1'b0;
        upd(1'b1, 30, 8, 1'b0);
        tick();
        upd(1'b0, 0, 0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_en", hist_enable, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_clr", hist_reset, 0);
        check("mid_rst_rej", n_reject, 0);
        check("mid_rst_to", timeout_err, 0);
        m_rej = 0;
        tick();
        rst = 1'b0;
        tick();
        clear_plan();
        q_r = '{11, 12};
        q_c = '{3, 7};
        run_window(1'b0, 0, 1'b0);

        // Reject counter saturation
        for (int w = 0; w < 258; w++)
            run_window(1'b1, 0, 1'b0);
        check("rej_sat", n_reject, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
